// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, single-outstanding imem read,
// one-entry instruction buffer with valid/ready hand-off and redirect handling.

module prefix_add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);
  logic [15:0] g, p, gn, pn, carry;

  // Kogge-Stone: log2(16) levels of generate/propagate combining, cin = 0.
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    gn = g;
    pn = p;
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 16; i++) begin
        if (i >= d) begin
          gn[i] = g[i] | (p[i] & g[i-d]);
          pn[i] = p[i] & p[i-d];
        end
      end
      g = gn;
      p = pn;
    end
    carry = {g[14:0], 1'b0};
    sum_o = a_i ^ b_i ^ carry;
  end
endmodule

module fetch_pc_unit #(
  parameter int          INSTR_W  = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [15:0]        out_pc
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [15:0]        pc_q, pc_d, pc_inc;
  logic               drop_q, drop_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        opc_q, opc_d;

  prefix_add16 u_pc_inc (.a_i(pc_q), .b_i(PC_INC), .sum_o(pc_inc));

  assign imem_addr = pc_q;
  assign out_valid = valid_q & ~redirect_valid;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    imem_req = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      case (state_q)
        S_WAIT: begin
          // An in-flight read must still be absorbed before a new one issues.
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              instr_d = imem_rdata;
              opc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_inc;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            valid_d  = 1'b0;
            imem_req = 1'b1;
            state_d  = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: latency-configurable memory plus a transaction-level
// model of fetch (outstanding read / one-entry buffer), checked every cycle.

module tb_fetch_pc_unit;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, redirect_valid, out_valid, out_ready;
  logic [15:0] imem_addr, imem_rdata, redirect_target, out_instr, out_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fetch_pc_unit #(.INSTR_W(16), .RESET_PC(RESET_PC), .PC_INC(16'd2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Reference model: PC, one outstanding read (maybe killed), one-entry buffer.
  logic [15:0] m_pc = RESET_PC;
  logic        m_outst = 1'b0, m_kill = 1'b0, m_bufv = 1'b0;
  logic [15:0] m_instr = 16'h0, m_opc = 16'h0;
  logic        last_req = 1'b0;

  // Memory: single pending read answered lat cycles after the request.
  logic        pend = 1'b0;
  int          due = 0;
  int          lat = 1;
  logic [15:0] paddr = 16'h0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [15:0] tg,
                      input logic rdy, input logic spur);
    logic        rv, ereq;
    logic [15:0] rdt;
    rv  = pend && (cyc == due);
    rdt = rv ? mem_word(paddr) : 16'h0;
    if (!pend && spur) begin
      rv  = 1'b1;
      rdt = 16'($urandom);
    end
    rst = r; redirect_valid = rd; redirect_target = tg; out_ready = rdy;
    imem_rvalid = rv; imem_rdata = rdt;
    #1;
    ereq = !r && !rd && !m_outst && (!m_bufv || rdy);
    last_req = ereq;
    chk("imem_req", {15'b0, imem_req}, {15'b0, ereq});
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {15'b0, out_valid}, {15'b0, m_bufv && !rd});
    chk("out_instr", out_instr, m_instr);
    chk("out_pc", out_pc, m_opc);
    // memory environment reacts to what the DUT actually did
    if (rv && pend) pend = 1'b0;
    if (r) pend = 1'b0;
    else if (imem_req) begin
      pend = 1'b1; due = cyc + lat; paddr = imem_addr;
    end
    // model update
    if (r) begin
      m_pc = RESET_PC; m_outst = 0; m_kill = 0; m_bufv = 0; m_instr = 0; m_opc = 0;
    end else if (rd) begin
      m_pc = tg;
      m_bufv = 1'b0;
      if (m_outst) begin
        if (rv) begin m_outst = 1'b0; m_kill = 1'b0; end
        else m_kill = 1'b1;
      end
    end else begin
      if (m_bufv && rdy) m_bufv = 1'b0;
      if (m_outst && rv) begin
        m_outst = 1'b0;
        if (m_kill) m_kill = 1'b0;
        else begin
          m_bufv = 1'b1; m_instr = rdt; m_opc = m_pc; m_pc = m_pc + 16'd2;
        end
      end
      if (ereq) m_outst = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_valid(input int maxc);
    int n = 0;
    while (!m_bufv && n < maxc) begin step(0, 0, 16'h0, 0, 0); n++; end
    chk("reach_valid", {15'b0, out_valid}, 16'h1);
  endtask

  task automatic step_until_req(input int maxc);
    int   n = 0;
    logic got = 1'b0;
    while (!got && n < maxc) begin step(0, 0, 16'h0, 1, 0); got = last_req; n++; end
    chk("reach_req", {15'b0, got}, 16'h1);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 0; redirect_target = 0; out_ready = 0;
    imem_rvalid = 0; imem_rdata = 0;
    @(posedge clk);
    #1;
    // 1: reset then streaming with 1-cycle memory
    lat = 1;
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 1, 0);
    repeat (8) step(0, 0, 16'h0, 1, 0);
    // 2: decode stalls for 5 cycles, then releases
    run_until_valid(10);
    repeat (5) step(0, 0, 16'h0, 0, 0);
    repeat (4) step(0, 0, 16'h0, 1, 0);
    // 3: 3-cycle memory, redirect in the cycle after the request
    lat = 3;
    step_until_req(10);
    step(0, 1, 16'h0100, 1, 0);
    repeat (12) step(0, 0, 16'h0, 1, 0);
    // 4: redirect coincident with rvalid, then redirect in HOLD with ready=1
    lat = 1;
    step_until_req(10);
    step(0, 1, 16'h0200, 1, 0);
    repeat (4) step(0, 0, 16'h0, 1, 0);
    run_until_valid(10);
    step(0, 1, 16'h0200, 1, 0);
    repeat (6) step(0, 0, 16'h0, 1, 0);
    // 5: PC wrap
    step(0, 1, 16'hFFFE, 1, 0);
    repeat (8) step(0, 0, 16'h0, 1, 0);
    // 6: reset during WAIT and during HOLD
    lat = 2;
    step_until_req(10);
    step(1, 0, 16'h0, 1, 0);
    repeat (6) step(0, 0, 16'h0, 1, 0);
    run_until_valid(10);
    step(1, 0, 16'h0, 0, 0);
    repeat (6) step(0, 0, 16'h0, 1, 0);
    // randomized traffic, including stray rvalid pulses and double redirects
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
           16'($urandom) & 16'hFFFE, $urandom_range(0, 9) < 7,
           $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
